// File: rtl/adc_seq_arbiter.sv
// Round-robin arbiter sharing one modular-ADC command/response port between
// NUM_REQ requesters, with response channel matching and a WAIT-state timeout.
module adc_seq_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic                   clock,
    input  logic                   aclr,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   req_channel,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [11:0]            sample,
    output logic                   err,
    output logic                   busy,
    output logic                   cmd_valid,
    output logic [4:0]             cmd_channel,
    input  logic                   cmd_ready,
    input  logic                   rsp_valid,
    input  logic [4:0]             rsp_channel,
    input  logic [11:0]            rsp_data
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW:0]        NREQ_W   = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0]      LAST_REQ = IW'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        RELEASE
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  owner;
    logic [4:0]     chan_q;
    logic [CW-1:0]  cnt;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic [IW:0]    scan_idx;
    logic [4:0]     pick_chan;

    // Scan requesters starting at the pointer, wrapping, and take the first one asserted.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (IW + 1)'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!pick_valid && req[scan_idx[IW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx[IW-1:0];
            end
        end
        pick_chan = req_channel[5*int'(pick_idx) +: 5];
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            chan_q      <= '0;
            cnt         <= '0;
            grant       <= '0;
            done        <= '0;
            sample      <= '0;
            err         <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_channel <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner       <= pick_idx;
                        grant       <= ONE_HOT0 << pick_idx;
                        chan_q      <= pick_chan;
                        cmd_valid   <= 1'b1;
                        cmd_channel <= pick_chan;
                        state       <= CMD;
                    end
                end
                CMD: begin
                    if (cmd_ready) begin
                        cmd_valid   <= 1'b0;
                        cmd_channel <= '0;
                        cnt         <= '0;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    // A matching response on the timeout edge still counts as a success.
                    if (rsp_valid && (rsp_channel == chan_q)) begin
                        sample <= rsp_data;
                        done   <= grant;
                        state  <= RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        sample <= 12'hFFF;
                        err    <= 1'b1;
                        done   <= grant;
                        state  <= RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (rsp_valid) begin
                            err <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    grant <= '0;
                    ptr   <= (owner == LAST_REQ) ? '0 : owner + 1'b1;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_seq_arbiter.sv
// Self-checking bench for adc_seq_arbiter: directed cases plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_adc_seq_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 8;

    logic              clock = 1'b0;
    logic              aclr;
    logic [NREQ-1:0]   req;
    logic [5*NREQ-1:0] req_channel;
    logic [NREQ-1:0]   grant;
    logic [NREQ-1:0]   done;
    logic [11:0]       sample;
    logic              err;
    logic              busy;
    logic              cmd_valid;
    logic [4:0]        cmd_channel;
    logic              cmd_ready;
    logic              rsp_valid;
    logic [4:0]        rsp_channel;
    logic [11:0]       rsp_data;

    logic [4:0] chan [NREQ];
    int total = 0;
    int bad   = 0;
    int exp_ptr = 0;

    assign req_channel = {chan[3], chan[2], chan[1], chan[0]};

    always #5 clock = ~clock;

    adc_seq_arbiter #(
        .NUM_REQ(NREQ),
        .TIMEOUT(TMO)
    ) dut (
        .clock(clock),
        .aclr(aclr),
        .req(req),
        .req_channel(req_channel),
        .grant(grant),
        .done(done),
        .sample(sample),
        .err(err),
        .busy(busy),
        .cmd_valid(cmd_valid),
        .cmd_channel(cmd_channel),
        .cmd_ready(cmd_ready),
        .rsp_valid(rsp_valid),
        .rsp_channel(rsp_channel),
        .rsp_data(rsp_data)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Round-robin rule: first asserted request at or after the pointer, wrapping.
    function automatic int pick_owner(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic run_txn(input logic [NREQ-1:0] reqv, input int ready_delay,
                           input int rsp_delay, input bit mm, input int mm_ch,
                           input logic [11:0] data, input bit tmo, input bit drop);
        int owner;
        logic [NREQ-1:0] onehot;
        logic [4:0] wrong;
        logic [11:0] exp_sample;
        owner  = pick_owner(reqv, exp_ptr);
        onehot = NREQ'(1 << owner);
        check_output("idle_busy", 32'(busy), 32'd0);
        req = reqv;
        step();
        check_output("cmd_grant", 32'(grant), 32'(onehot));
        check_output("cmd_valid", 32'(cmd_valid), 32'd1);
        check_output("cmd_channel", 32'(cmd_channel), 32'(chan[owner]));
        check_output("cmd_busy", 32'(busy), 32'd1);
        if (drop) req = '0;
        for (int i = 0; i < ready_delay; i++) begin
            rsp_valid   = 1'($urandom_range(0, 1));
            rsp_channel = chan[owner];
            rsp_data    = 12'($urandom);
            step();
            check_output("cmd_hold_valid", 32'(cmd_valid), 32'd1);
            check_output("cmd_hold_channel", 32'(cmd_channel), 32'(chan[owner]));
            check_output("cmd_hold_done", 32'(done), 32'd0);
            check_output("cmd_hold_err", 32'(err), 32'd0);
        end
        rsp_valid = 1'b0;
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        check_output("wait_cmd_valid", 32'(cmd_valid), 32'd0);
        check_output("wait_cmd_channel", 32'(cmd_channel), 32'd0);
        check_output("wait_grant", 32'(grant), 32'(onehot));
        if (tmo) begin
            for (int i = 1; i < TMO; i++) begin
                step();
                check_output("tmo_pending_done", 32'(done), 32'd0);
                check_output("tmo_pending_err", 32'(err), 32'd0);
            end
            step();
            exp_sample = 12'hFFF;
            check_output("tmo_err", 32'(err), 32'd1);
        end else begin
            for (int i = 0; i < rsp_delay; i++) begin
                step();
                check_output("wait_done", 32'(done), 32'd0);
                check_output("wait_err", 32'(err), 32'd0);
            end
            if (mm) begin
                wrong = (mm_ch >= 0) ? 5'(mm_ch) : (chan[owner] ^ 5'($urandom_range(1, 31)));
                rsp_valid   = 1'b1;
                rsp_channel = wrong;
                rsp_data    = 12'($urandom);
                step();
                rsp_valid = 1'b0;
                check_output("mm_err", 32'(err), 32'd1);
                check_output("mm_done", 32'(done), 32'd0);
                step();
                check_output("mm_err_clear", 32'(err), 32'd0);
                check_output("mm_still_wait", 32'(done), 32'd0);
            end
            rsp_valid   = 1'b1;
            rsp_channel = chan[owner];
            rsp_data    = data;
            step();
            rsp_valid  = 1'b0;
            exp_sample = data;
            check_output("match_err", 32'(err), 32'd0);
        end
        check_output("rel_done", 32'(done), 32'(onehot));
        check_output("rel_sample", 32'(sample), 32'(exp_sample));
        check_output("rel_grant", 32'(grant), 32'(onehot));
        check_output("rel_busy", 32'(busy), 32'd1);
        step();
        check_output("post_done", 32'(done), 32'd0);
        check_output("post_grant", 32'(grant), 32'd0);
        check_output("post_busy", 32'(busy), 32'd0);
        check_output("post_err", 32'(err), 32'd0);
        check_output("post_sample_held", 32'(sample), 32'(exp_sample));
        exp_ptr = (owner + 1) % NREQ;
        req = '0;
    endtask

    initial begin
        int owner;
        bit mm;
        aclr = 1'b1;
        req = '0;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_channel = '0;
        rsp_data = '0;
        for (int j = 0; j < NREQ; j++) chan[j] = 5'($urandom);
        step();
        step();
        check_output("rst_grant", 32'(grant), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_sample", 32'(sample), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_output("rst_cmd_channel", 32'(cmd_channel), 32'd0);
        aclr = 1'b0;
        step();

        $display("[TB] round-robin with all requests held");
        for (int n = 0; n < 5; n++) run_txn(4'b1111, 0, 0, 0, -1, 12'($urandom), 0, 0);

        $display("[TB] single requester, temperature channel");
        chan[0] = 5'd17;
        run_txn(4'b0001, 0, 3, 0, -1, 12'hD70, 0, 0);

        $display("[TB] command back-pressure");
        run_txn(4'b0010, 5, 1, 0, -1, 12'h456, 0, 0);

        $display("[TB] channel mismatch then match");
        chan[2] = 5'd17;
        run_txn(4'b0100, 0, 1, 1, 3, 12'h123, 0, 0);

        $display("[TB] timeout");
        run_txn(4'b1000, 0, 0, 0, -1, 12'h000, 1, 0);

        $display("[TB] match on the timeout edge, request dropped after grant");
        run_txn(4'b0001, 0, TMO - 1, 0, -1, 12'h5A5, 0, 0);
        run_txn(4'b0010, 1, 2, 0, -1, 12'h3C3, 0, 1);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 25; n++) begin
            for (int j = 0; j < NREQ; j++) chan[j] = 5'($urandom);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                rsp_valid   = 1'($urandom_range(0, 1));
                rsp_channel = 5'($urandom);
                step();
                rsp_valid = 1'b0;
                check_output("idle_rsp_err", 32'(err), 32'd0);
                check_output("idle_rsp_done", 32'(done), 32'd0);
            end
            mm = 1'($urandom_range(0, 1));
            run_txn(4'($urandom_range(1, 15)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, mm ? 5 : 7)), mm, -1, 12'($urandom),
                    ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during WAIT");
        run_txn(4'b1111, 0, 0, 0, -1, 12'hABC, 0, 0);
        owner = pick_owner(4'b1111, exp_ptr);
        req = 4'b1111;
        step();
        cmd_ready = 1'b1;
        step();
        cmd_ready = 1'b0;
        step();
        aclr = 1'b1;
        #1;
        check_output("arst_grant", 32'(grant), 32'd0);
        check_output("arst_busy", 32'(busy), 32'd0);
        check_output("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_output("arst_sample", 32'(sample), 32'd0);
        req = '0;
        step();
        aclr = 1'b0;
        rsp_valid   = 1'b1;
        rsp_channel = chan[owner];
        rsp_data    = 12'h777;
        step();
        rsp_valid = 1'b0;
        check_output("arst_rsp_busy", 32'(busy), 32'd0);
        check_output("arst_rsp_done", 32'(done), 32'd0);
        check_output("arst_rsp_err", 32'(err), 32'd0);
        check_output("arst_rsp_sample", 32'(sample), 32'd0);
        exp_ptr = 0;
        run_txn(4'b1111, 0, 0, 0, -1, 12'h0F0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
